stage4_execute: RTL and testbench

Stage-4 execute unit of the five-stage integer pipeline. It sits between the stage-3/4 pipeline latch and the stage-4/5 latch, computing `alu_result` for every instruction. It forwards `rd` and the 16-bit instruction flags unchanged. Single-cycle ALU ops resolve combinationally in one cycle. Multiply and divide run on a shared iterative datapath and assert `stall` until their result is ready, inserting bubbles into the stage-4/5 latch meanwhile.

---
 rtl/stage4_execute_if.sv | 27 ++
 rtl/stage4_execute.sv | 210 +++++++++++++++++++++
 tb/tb_stage4_execute.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage4_execute_if.sv
// Bundle between the stage-3/4 latch, the execute unit and the stage-4/5 latch.
// valid_in presents an instruction; while stall is 1 upstream holds every input
// stable, and the instruction is consumed at the first edge where stall is 0.
interface stage4_execute_if;
  logic        flush;
  logic        valid_in;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic [15:0] instr_flags_in;
  logic [31:0] alu_result_out;
  logic [4:0]  rd_out;
  logic [15:0] instr_flags_out;
  logic        result_valid;
  logic        stall;

  modport master (
    output flush, valid_in, op, a, b, rd_in, instr_flags_in,
    input  alu_result_out, rd_out, instr_flags_out, result_valid, stall
  );

  modport slave (
    input  flush, valid_in, op, a, b, rd_in, instr_flags_in,
    output alu_result_out, rd_out, instr_flags_out, result_valid, stall
  );
endinterface

// File: rtl/stage4_execute.sv
// Stage-4 execute unit: combinational single-cycle ALU plus a shared iterative
// shift-add multiplier / restoring divider that stalls upstream until done.
module stage4_execute #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stage4_execute_if.slave        ex,
  output logic [1:0]             dbg_state
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
  localparam logic [3:0] OP_PASSB = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [15:0]       flags_q, flags_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  // hi holds the upper product half or the partial remainder,
  // lo holds the multiplier/lower product or the dividend/quotient.
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              in_multi;
  logic              in_mul;
  logic              q_mul;
  logic [XLEN-1:0]   alu_comb;
  logic [XLEN-1:0]   done_result;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;

  assign in_multi = (ex.op == OP_MUL) || (ex.op == OP_MULHU) ||
                    (ex.op == OP_DIVU) || (ex.op == OP_REMU);
  assign in_mul   = (ex.op == OP_MUL) || (ex.op == OP_MULHU);
  assign q_mul    = (op_q == OP_MUL) || (op_q == OP_MULHU);

  // Single-cycle ALU on the live inputs.
  always_comb begin
    alu_comb = '0;
    case (ex.op)
      OP_ADD:   alu_comb = ex.a + ex.b;
      OP_SUB:   alu_comb = ex.a - ex.b;
      OP_AND:   alu_comb = ex.a & ex.b;
      OP_OR:    alu_comb = ex.a | ex.b;
      OP_XOR:   alu_comb = ex.a ^ ex.b;
      OP_SLL:   alu_comb = ex.a << ex.b[4:0];
      OP_SRL:   alu_comb = ex.a >> ex.b[4:0];
      OP_SRA:   alu_comb = XLEN'($signed(ex.a) >>> ex.b[4:0]);
      OP_SLT:   alu_comb = {{(XLEN-1){1'b0}}, ($signed(ex.a) < $signed(ex.b))};
      OP_SLTU:  alu_comb = {{(XLEN-1){1'b0}}, (ex.a < ex.b)};
      OP_PASSB: alu_comb = ex.b;
      default:  alu_comb = '0;
    endcase
  end

  // One iteration of each datapath; only the one matching op_q is used.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opa_q : {XLEN{1'b0}})};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
  end

  always_comb begin
    done_result = '0;
    case (op_q)
      OP_MUL:   done_result = lo_q;
      OP_MULHU: done_result = hi_q;
      OP_DIVU:  done_result = lo_q;
      OP_REMU:  done_result = hi_q;
      default:  done_result = '0;
    endcase
  end

  // Outputs are forced to a bubble during reset and during any flush cycle.
  always_comb begin
    ex.alu_result_out  = '0;
    ex.rd_out          = '0;
    ex.instr_flags_out = '0;
    ex.result_valid    = 1'b0;
    ex.stall           = 1'b0;
    if (rst_n && !ex.flush) begin
      case (state_q)
        IDLE: begin
          if (ex.valid_in) begin
            if (in_multi) begin
              ex.stall = 1'b1;
            end else begin
              ex.alu_result_out  = alu_comb;
              ex.rd_out          = ex.rd_in;
              ex.instr_flags_out = ex.instr_flags_in;
              ex.result_valid    = 1'b1;
            end
          end
        end
        BUSY: ex.stall = 1'b1;
        DONE: begin
          ex.alu_result_out  = done_result;
          ex.rd_out          = rd_q;
          ex.instr_flags_out = flags_q;
          ex.result_valid    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    flags_d = flags_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (ex.valid_in && in_multi) begin
          op_d    = ex.op;
          rd_d    = ex.rd_in;
          flags_d = ex.instr_flags_in;
          opa_d   = ex.a;
          opb_d   = ex.b;
          hi_d    = '0;
          lo_d    = in_mul ? ex.b : ex.a;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (q_mul) begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
          // No borrow: the divisor fits, keep the difference and shift in a 1.
          hi_d = div_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ex.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      flags_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      flags_q <= flags_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_stage4_execute.sv
// Bench for stage4_execute: directed cases plus randomized ops against an
// arithmetic reference model, with stall-length and bubble checks.
module tb_stage4_execute;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stage4_execute_if ex_if ();
  logic [1:0] dbg_state;

  stage4_execute #(.XLEN(32), .ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex        (ex_if.slave),
    .dbg_state (dbg_state)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [52:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa;
    p  = {32'd0, a} * {32'd0, b};
    sa = a;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return sa >>> b[4:0];
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 32'd0) ? a : a % b;
      4'd14: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_multi(input logic [3:0] op);
    return (op >= 4'd10) && (op <= 4'd13);
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [15:0] fl);
    ex_if.valid_in       = 1'b1;
    ex_if.op             = op;
    ex_if.a              = a;
    ex_if.b              = b;
    ex_if.rd_in          = rd;
    ex_if.instr_flags_in = fl;
  endtask

  task automatic drive_idle();
    ex_if.valid_in       = 1'b0;
    ex_if.op             = 4'($urandom_range(0, 15));
    ex_if.a              = $urandom;
    ex_if.b              = $urandom;
    ex_if.rd_in          = 5'($urandom_range(0, 31));
    ex_if.instr_flags_in = 16'($urandom_range(0, 65535));
  endtask

  task automatic check_bubble(input string tag, input logic stall_exp);
    check_eq(tag, {9'd0, ex_if.stall, ex_if.result_valid, ex_if.alu_result_out,
                   ex_if.rd_out, ex_if.instr_flags_out},
             {9'd0, stall_exp, 1'b0, 53'd0});
  endtask

  task automatic check_result(input string tag);
    logic [52:0] e;
    e = exp_q.pop_front();
    check_eq(tag, {9'd0, ex_if.result_valid, ex_if.stall, ex_if.instr_flags_out,
                   ex_if.rd_out, ex_if.alu_result_out},
             {9'd0, 1'b1, 1'b0, e});
  endtask

  // Called just after an active edge; returns just after the edge that
  // consumes the instruction.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [15:0] fl);
    int unsigned n_stall;
    bit got;
    exp_q.push_back({fl, rd, model_alu(op, a, b)});
    drive(op, a, b, rd, fl);
    if (!is_multi(op)) begin
      @(negedge clk);
      check_result(tag);
    end else begin
      n_stall = 0;
      got = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk);
        if (ex_if.result_valid) begin
          got = 1'b1;
          break;
        end
        check_bubble({tag, "_bubble"}, 1'b1);
        @(posedge clk);
        #1;
        n_stall++;
      end
      check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
      check_eq({tag, "_stall_len"}, 64'(n_stall), 64'd33);
      if (got) check_result(tag);
      else void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    // Reset with a live instruction on the inputs: outputs must stay 0.
    ex_if.flush = 1'b0;
    drive(4'd0, 32'd5, 32'd7, 5'd3, 16'h00A5);
    #12;
    check_bubble("reset_out", 1'b0);
    check_eq("reset_state", 64'(dbg_state), 64'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add",   4'd0,  32'd5,          32'd7,          5'd3,  16'h00A5);
    run_op("sub",   4'd1,  32'd0,          32'd1,          5'd4,  16'h0011);
    run_op("sra",   4'd7,  32'h8000_0000,  32'h21,         5'd5,  16'h1234);
    run_op("slt",   4'd8,  32'hFFFF_FFFF,  32'd0,          5'd6,  16'h0001);
    run_op("sltu",  4'd9,  32'hFFFF_FFFF,  32'd0,          5'd7,  16'h0002);
    run_op("rsvd",  4'd15, 32'h1111_2222,  32'h3333_4444,  5'd8,  16'h0003);
    run_op("mul",   4'd10, 32'h0001_0000,  32'h0001_0000,  5'd9,  16'hBEEF);
    run_op("mulhu", 4'd11, 32'h0001_0000,  32'h0001_0000,  5'd10, 16'hCAFE);
    run_op("divu",  4'd12, 32'd100,        32'd7,          5'd11, 16'h0F0F);
    run_op("remu",  4'd13, 32'd100,        32'd7,          5'd12, 16'hF0F0);
    run_op("divu0", 4'd12, 32'hDEAD_BEEF,  32'd0,          5'd13, 16'h5555);
    run_op("remu0", 4'd13, 32'h0000_1234,  32'd0,          5'd14, 16'hAAAA);

    drive_idle();
    @(negedge clk);
    check_bubble("idle", 1'b0);
    @(posedge clk);
    #1;

    // Flush a DIVU in its tenth cycle after acceptance.
    drive(4'd12, 32'd1000, 32'd3, 5'd15, 16'h7777);
    @(negedge clk);
    check_bubble("flush_accept", 1'b1);
    repeat (10) @(posedge clk);
    #1;
    ex_if.flush = 1'b1;
    @(negedge clk);
    check_bubble("flush_cycle", 1'b0);
    @(posedge clk);
    #1;
    ex_if.flush = 1'b0;
    check_eq("flush_idle", 64'(dbg_state), 64'd0);
    run_op("after_flush_add", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd16, 16'h0101);
    check_eq("flush_nothing_pending", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of a MUL.
    drive(4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 16'h4242);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_bubble("reset_mid", 1'b0);
    check_eq("reset_mid_state", 64'(dbg_state), 64'd0);
    drive_idle();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("mul_after_reset", 4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 16'h4242);

    // Randomized ops with occasional idle gaps and zero/small divisors.
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 3) == 0) begin
        drive_idle();
        @(negedge clk);
        check_bubble("rand_idle", 1'b0);
        @(posedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
